// File: rtl/radio_pull_requant_pkg.sv
// Shared defaults, sample/entry types and the requantisation helper for radio_pull_requant.
// Build option: RADIO_PULL_SAT_EN selects saturation; without it the result wraps.
package radio_pull_pkg;

  localparam int DEF_N_LANES = 8;
  localparam int DEF_IN_W    = 16;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_SHIFT   = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_CNT_W   = 16;

  typedef logic signed [DEF_IN_W-1:0]  sample_in_t;
  typedef logic signed [DEF_OUT_W-1:0] sample_out_t;

  typedef struct packed {
    sample_out_t tdata;
    logic        tlast;
  } fifo_entry_t;

  // Round-half-up then shift; 32-bit arithmetic cannot overflow for IN_W <= 30,
  // so it matches an IN_W+1 bit computation. Result is sign-correct in OUT_W bits.
  function automatic logic signed [31:0] requant(input logic signed [31:0] x,
                                                 input int shift, input int outW);
    logic signed [31:0] r;
    r = (x + (32'sd1 <<< (shift - 1))) >>> shift;
`ifdef RADIO_PULL_SAT_EN
    begin
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (outW - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
    end
`else
    r = (r <<< (32 - outW)) >>> (32 - outW);
`endif
    return r;
  endfunction

endpackage

// File: rtl/radio_pull_requant_if.sv
// Stream, statistics and control bundle between the AD capture streams and radio_pull_requant.
// Handshake: a transfer happens on a clock edge where tvalid && tready; sources here may offer regardless of tready.
interface radio_pull_requant_if
  import radio_pull_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int CNT_W   = DEF_CNT_W
) ();

  logic [N_LANES-1:0] s_axis_inputI_tvalid;
  logic [N_LANES-1:0] s_axis_inputI_tlast;
  logic [N_LANES-1:0] s_axis_inputI_tready;
  logic [IN_W-1:0]    s_axis_inputI_tdata [N_LANES];

  logic [N_LANES-1:0] s_axis_inputQ_tvalid;
  logic [N_LANES-1:0] s_axis_inputQ_tlast;
  logic [N_LANES-1:0] s_axis_inputQ_tready;
  logic [IN_W-1:0]    s_axis_inputQ_tdata [N_LANES];

  logic [N_LANES-1:0] m_axis_outputI_tvalid;
  logic [N_LANES-1:0] m_axis_outputI_tlast;
  logic [N_LANES-1:0] m_axis_outputI_tready;
  logic [OUT_W-1:0]   m_axis_outputI_tdata [N_LANES];

  logic [N_LANES-1:0] m_axis_outputQ_tvalid;
  logic [N_LANES-1:0] m_axis_outputQ_tlast;
  logic [N_LANES-1:0] m_axis_outputQ_tready;
  logic [OUT_W-1:0]   m_axis_outputQ_tdata [N_LANES];

  logic [CNT_W-1:0]   drop_cnt_I [N_LANES];
  logic [CNT_W-1:0]   drop_cnt_Q [N_LANES];
  logic               overflow;
  logic               stat_clr;

  modport slave (
    input  s_axis_inputI_tvalid, s_axis_inputI_tlast, s_axis_inputI_tdata,
    output s_axis_inputI_tready,
    input  s_axis_inputQ_tvalid, s_axis_inputQ_tlast, s_axis_inputQ_tdata,
    output s_axis_inputQ_tready,
    output m_axis_outputI_tvalid, m_axis_outputI_tlast, m_axis_outputI_tdata,
    input  m_axis_outputI_tready,
    output m_axis_outputQ_tvalid, m_axis_outputQ_tlast, m_axis_outputQ_tdata,
    input  m_axis_outputQ_tready,
    output drop_cnt_I, drop_cnt_Q, overflow,
    input  stat_clr
  );

  modport master (
    output s_axis_inputI_tvalid, s_axis_inputI_tlast, s_axis_inputI_tdata,
    input  s_axis_inputI_tready,
    output s_axis_inputQ_tvalid, s_axis_inputQ_tlast, s_axis_inputQ_tdata,
    input  s_axis_inputQ_tready,
    input  m_axis_outputI_tvalid, m_axis_outputI_tlast, m_axis_outputI_tdata,
    output m_axis_outputI_tready,
    input  m_axis_outputQ_tvalid, m_axis_outputQ_tlast, m_axis_outputQ_tdata,
    output m_axis_outputQ_tready,
    input  drop_cnt_I, drop_cnt_Q, overflow,
    output stat_clr
  );

endinterface

// File: rtl/radio_pull_requant_lane.sv
// One stream of radio_pull_requant: requant register, FWFT FIFO with pointer wrap bit,
// pending-tlast carry and saturating drop counter. RADIO_PULL_SAT_EN acts inside requant().
module radio_pull_lane
  import radio_pull_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk_250m,
  input  logic                   reset,
  input  logic                   statClr,
  input  logic                   sTvalid,
  input  logic                   sTlast,
  input  logic signed [IN_W-1:0] sTdata,
  output logic                   sTready,
  output logic                   mTvalid,
  output logic                   mTlast,
  output logic [OUT_W-1:0]       mTdata,
  input  logic                   mTready,
  output logic [CNT_W-1:0]       dropCnt,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] readyLimit = (AW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [OUT_W-1:0] tdata;
    logic             tlast;
  } entry_t;

  logic signed [31:0] rqFull;
  logic               unusedRqHi;
  logic               rqValid;
  entry_t             rqEntry;
  entry_t             mem [DEPTH];
  entry_t             headEntry;
  entry_t             writeEntry;
  logic [AW:0]        wrPtr;
  logic [AW:0]        rdPtr;
  logic [AW:0]        count;
  logic               full;
  logic               pop;
  logic               doWrite;
  logic               drop;
  logic               pendingLast;

  assign rqFull     = requant(32'(sTdata), SHIFT, OUT_W);
  assign unusedRqHi = ^rqFull[31:OUT_W];

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      rqValid <= 1'b0;
      rqEntry <= '0;
    end else begin
      rqValid <= sTvalid;
      if (sTvalid) begin
        rqEntry.tdata <= rqFull[OUT_W-1:0];
        rqEntry.tlast <= sTlast;
      end
    end
  end

  assign count   = wrPtr - rdPtr;
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign mTvalid = (wrPtr != rdPtr);
  assign pop     = mTvalid && mTready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign doWrite = rqValid && (!full || pop);
  assign drop    = rqValid && !doWrite;
  // One slot stays reserved for the sample already sitting in the requant register.
  assign sTready = (count <= readyLimit);

  always_comb begin
    writeEntry       = rqEntry;
    writeEntry.tlast = rqEntry.tlast | pendingLast;
  end

  always_ff @(posedge clk_250m) begin
    if (doWrite) mem[wrPtr[AW-1:0]] <= writeEntry;
  end

  always_ff @(posedge clk_250m) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      pendingLast <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)     rdPtr <= rdPtr + (AW+1)'(1);
      if (doWrite)                pendingLast <= 1'b0;
      else if (drop && rqEntry.tlast) pendingLast <= 1'b1;
    end
  end

  always_ff @(posedge clk_250m) begin
    if (reset || statClr) begin
      dropCnt  <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropCnt != '1) dropCnt <= dropCnt + CNT_W'(1);
    end
  end

  assign headEntry = mem[rdPtr[AW-1:0]];
  assign mTdata    = mTvalid ? headEntry.tdata : '0;
  assign mTlast    = mTvalid ? headEntry.tlast : 1'b0;

endmodule

// File: rtl/radio_pull_requant.sv
// Top of the parametrised I/Q pull stage: 2*N_LANES independent requant+FIFO streams.
// Build option: RADIO_PULL_SAT_EN (saturate instead of wrap on requantisation).
module radio_pull_requant
  import radio_pull_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT   = DEF_SHIFT,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                  clk_250m,
  input  logic                  reset,
  radio_pull_requant_if.slave   bus
);

  logic [2*N_LANES-1:0] laneOverflow;

  for (genvar g = 0; g < N_LANES; g++) begin : gLane
    radio_pull_lane #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) uLaneI (
      .clk_250m (clk_250m),
      .reset    (reset),
      .statClr  (bus.stat_clr),
      .sTvalid  (bus.s_axis_inputI_tvalid[g]),
      .sTlast   (bus.s_axis_inputI_tlast[g]),
      .sTdata   (bus.s_axis_inputI_tdata[g]),
      .sTready  (bus.s_axis_inputI_tready[g]),
      .mTvalid  (bus.m_axis_outputI_tvalid[g]),
      .mTlast   (bus.m_axis_outputI_tlast[g]),
      .mTdata   (bus.m_axis_outputI_tdata[g]),
      .mTready  (bus.m_axis_outputI_tready[g]),
      .dropCnt  (bus.drop_cnt_I[g]),
      .overflow (laneOverflow[2*g])
    );

    radio_pull_lane #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) uLaneQ (
      .clk_250m (clk_250m),
      .reset    (reset),
      .statClr  (bus.stat_clr),
      .sTvalid  (bus.s_axis_inputQ_tvalid[g]),
      .sTlast   (bus.s_axis_inputQ_tlast[g]),
      .sTdata   (bus.s_axis_inputQ_tdata[g]),
      .sTready  (bus.s_axis_inputQ_tready[g]),
      .mTvalid  (bus.m_axis_outputQ_tvalid[g]),
      .mTlast   (bus.m_axis_outputQ_tlast[g]),
      .mTdata   (bus.m_axis_outputQ_tdata[g]),
      .mTready  (bus.m_axis_outputQ_tready[g]),
      .dropCnt  (bus.drop_cnt_Q[g]),
      .overflow (laneOverflow[2*g+1])
    );
  end

  assign bus.overflow = |laneOverflow;

endmodule
